// File: rtl/mfcc_pkg.sv
// Shared constants, FSM encoding and output beat type for the MFCC mel-filterbank stage.
package mfcc_pkg;
    localparam int N_BINS = 256;
    localparam int N_FILT = 26;
    localparam int P_W    = 32;
    localparam int ACC_W  = 48;
    localparam int ROM_AW = 9;
    localparam int ROM_DW = 8;
    localparam int IDX_W  = 5;

    localparam int BIN_W  = ROM_AW - 1;
    localparam int PROD_W = P_W + 9;

    // ROM address MSB selects the weight half or the filter-index half
    localparam logic ROM_HALF_W = 1'b0;
    localparam logic ROM_HALF_F = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_W,
        ST_FETCH_F,
        ST_MAC,
        ST_FLUSH
    } state_t;

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic [IDX_W-1:0] idx;
        logic             last;
    } out_beat_t;
endpackage

// File: rtl/mel_filterbank_mac_if.sv
// Sample stream in, coefficient ROM read port, filter-energy stream out.
interface mel_filterbank_mac_if;
    import mfcc_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [P_W-1:0]    in_data;
    logic              in_last;
    logic [ROM_AW-1:0] rom_addr;
    logic [ROM_DW-1:0] rom_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              frame_err;

    modport master (
        output in_valid, in_data, in_last, rom_rd_data, out_ready,
        input  in_ready, rom_addr, out_valid, out_data, out_idx, out_last, frame_err
    );

    modport slave (
        input  in_valid, in_data, in_last, rom_rd_data, out_ready,
        output in_ready, rom_addr, out_valid, out_data, out_idx, out_last, frame_err
    );
endinterface

// File: rtl/mel_mac_unit.sv
// Rising/falling-edge accumulators; on a filter advance the rising sum becomes the falling sum.
module mel_mac_unit
    import mfcc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              advance,
    input  logic              add_rise,
    input  logic              add_fall,
    input  logic [P_W-1:0]    p,
    input  logic [ROM_DW-1:0] w,
    output logic [ACC_W-1:0]  acc_rise,
    output logic [ACC_W-1:0]  acc_fall
);
    logic [8:0]        w_rise, w_fall;
    logic [PROD_W-1:0] prod_rise, prod_fall;
    logic [ACC_W-1:0]  base_rise, base_fall;
    logic [ACC_W-1:0]  term_rise, term_fall;

    // 256 - w is 1..256, so the falling weight needs the ninth bit
    assign w_rise    = {1'b0, w};
    assign w_fall    = 9'd256 - w_rise;
    assign prod_rise = PROD_W'(p) * PROD_W'(w_rise);
    assign prod_fall = PROD_W'(p) * PROD_W'(w_fall);

    assign base_rise = advance ? '0 : acc_rise;
    assign base_fall = advance ? acc_rise : acc_fall;
    assign term_rise = add_rise ? {{(ACC_W-PROD_W){1'b0}}, prod_rise} : '0;
    assign term_fall = add_fall ? {{(ACC_W-PROD_W){1'b0}}, prod_fall} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_rise <= '0;
            acc_fall <= '0;
        end else if (clr) begin
            acc_rise <= '0;
            acc_fall <= '0;
        end else if (en) begin
            acc_rise <= base_rise + term_rise;
            acc_fall <= base_fall + term_fall;
        end
    end
endmodule

// File: rtl/mel_filterbank_mac.sv
// Per-bin ROM fetch + mel MAC; emits exactly N_FILT filter energies per frame.
module mel_filterbank_mac
    import mfcc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    mel_filterbank_mac_if.slave  bus
);
    state_t            state_q, state_d;
    logic [BIN_W-1:0]  bin_q;
    logic [IDX_W-1:0]  cur_f_q, next_out_q, cur_f_nx;
    logic [P_W-1:0]    p_q;
    logic              last_q;
    logic [ROM_DW-1:0] w_q, f_q;
    logic              in_ready_q, out_valid_q, frame_err_q;
    out_beat_t         out_q, beat_d;
    logic [ACC_W-1:0]  acc_rise, acc_fall;

    logic accept, f_skip, advance, emit_mac, slot_free, frame_end, bin_is_last;
    logic mac_go, load_out, flush_exit, frame_err_d;

    assign accept      = bus.in_valid && in_ready_q;
    assign f_skip      = f_q > ROM_DW'(N_FILT);
    // any upward jump is taken as a single step so emission order stays contiguous
    assign advance     = !f_skip && (f_q > ROM_DW'(cur_f_q));
    assign cur_f_nx    = advance ? cur_f_q + 1'b1 : cur_f_q;
    assign emit_mac    = advance && (cur_f_q != '0);
    assign slot_free   = !out_valid_q || bus.out_ready;
    assign bin_is_last = bin_q == BIN_W'(N_BINS-1);
    assign frame_end   = last_q || bin_is_last;
    assign frame_err_d = mac_go && frame_end && (last_q != bin_is_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load_out   = 1'b0;
        beat_d     = '0;
        mac_go     = 1'b0;
        flush_exit = 1'b0;
        case (state_q)
            ST_IDLE:    if (accept) state_d = ST_FETCH_W;
            ST_FETCH_W: state_d = ST_FETCH_F;
            ST_FETCH_F: state_d = ST_MAC;
            ST_MAC: begin
                if (!(emit_mac && !slot_free)) begin
                    mac_go      = 1'b1;
                    load_out    = emit_mac;
                    beat_d.data = acc_fall;
                    beat_d.idx  = next_out_q;
                    beat_d.last = next_out_q == IDX_W'(N_FILT-1);
                    state_d     = frame_end ? ST_FLUSH : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (slot_free) begin
                    load_out    = 1'b1;
                    beat_d.idx  = next_out_q;
                    beat_d.last = next_out_q == IDX_W'(N_FILT-1);
                    // pending falling sum first, then rising sum, then zeros
                    if (cur_f_q != '0 && next_out_q == cur_f_q - 1'b1)
                        beat_d.data = acc_fall;
                    else if (next_out_q == cur_f_q)
                        beat_d.data = acc_rise;
                    if (next_out_q == IDX_W'(N_FILT-1)) begin
                        flush_exit = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q       <= '0;
            cur_f_q     <= '0;
            next_out_q  <= '0;
            p_q         <= '0;
            last_q      <= 1'b0;
            w_q         <= '0;
            f_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            in_ready_q  <= state_d == ST_IDLE;
            frame_err_q <= frame_err_d;
            if (accept) begin
                p_q    <= bus.in_data;
                last_q <= bus.in_last;
            end
            if (state_q == ST_FETCH_W) w_q <= bus.rom_rd_data;
            if (state_q == ST_FETCH_F) f_q <= bus.rom_rd_data;
            if (mac_go) begin
                cur_f_q <= cur_f_nx;
                if (!frame_end) bin_q <= bin_q + 1'b1;
            end
            if (load_out) next_out_q <= next_out_q + 1'b1;
            if (flush_exit) begin
                bin_q      <= '0;
                cur_f_q    <= '0;
                next_out_q <= '0;
            end
            if (load_out) begin
                out_q       <= beat_d;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    mel_mac_unit u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush_exit),
        .en       (mac_go && !f_skip),
        .advance  (advance),
        .add_rise (cur_f_nx < IDX_W'(N_FILT)),
        .add_fall (cur_f_nx != '0),
        .p        (p_q),
        .w        (w_q),
        .acc_rise (acc_rise),
        .acc_fall (acc_fall)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.rom_addr  = {(state_q == ST_FETCH_W) ? ROM_HALF_F : ROM_HALF_W, bin_q};
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q.data;
    assign bus.out_idx   = out_q.idx;
    assign bus.out_last  = out_q.last;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_mel_filterbank_mac.sv
// Scoreboarded bench for mel_filterbank_mac with a synchronous-read coefficient ROM model.
module tb_mel_filterbank_mac;
    import mfcc_pkg::*;

    typedef logic [ACC_W+IDX_W:0] beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mel_filterbank_mac_if bus();

    mel_filterbank_mac dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [ROM_DW-1:0] rom   [0:(1<<ROM_AW)-1];
    logic [P_W-1:0]    pw    [0:N_BINS-1];
    logic [ACC_W-1:0]  exp_e [0:N_FILT-1];
    beat_t             sb[$];

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int lasts_seen = 0;
    bit rdy_rand = 1'b0;

    always @(posedge clk) bus.rom_rd_data <= rom[bus.rom_addr];

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rdy_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
    end

    // scoreboard: every accepted beat must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_err === 1'b1) err_pulses++;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got idx=%0d data=%0h, required no output", bus.out_idx, bus.out_data);
                end else begin
                    beat_t exp_b;
                    exp_b = sb.pop_front();
                    if ({bus.out_data, bus.out_idx, bus.out_last} !== exp_b) begin
                        errors++;
                        $display("FAIL out_beat: got data=%0h idx=%0d last=%0b, required data=%0h idx=%0d last=%0b",
                                 bus.out_data, bus.out_idx, bus.out_last,
                                 exp_b[ACC_W+IDX_W:IDX_W+1], exp_b[IDX_W:1], exp_b[0]);
                    end
                end
                if (bus.out_last === 1'b1) lasts_seen++;
            end
        end
    end

    task automatic load_rom_mel();
        for (int b = 0; b < N_BINS; b++) begin
            rom[b]          = ROM_DW'(((b % 9) * 255) / 8);
            rom[N_BINS + b] = (b < 243) ? ROM_DW'(b / 9) : ROM_DW'(31);
        end
    endtask

    task automatic load_rom_single();
        for (int b = 0; b < N_BINS; b++) begin
            rom[b]          = (b < 128) ? ROM_DW'(255) : ROM_DW'(0);
            rom[N_BINS + b] = (b < 128) ? ROM_DW'(0) : ROM_DW'(1);
        end
    endtask

    // reference: bin b adds P*w to filter f and P*(256-w) to filter f-1
    task automatic model_frame(input int nb);
        for (int i = 0; i < N_FILT; i++) exp_e[i] = '0;
        for (int b = 0; b < nb; b++) begin
            int fi;
            fi = int'(rom[N_BINS + b]);
            if (fi < N_FILT)
                exp_e[fi] = exp_e[fi] + ACC_W'(pw[b]) * ACC_W'(rom[b]);
            if (fi >= 1 && fi <= N_FILT)
                exp_e[fi-1] = exp_e[fi-1] + ACC_W'(pw[b]) * (ACC_W'(256) - ACC_W'(rom[b]));
        end
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++)
            sb.push_back({exp_e[i], IDX_W'(i), (i == N_FILT-1)});
    endtask

    task automatic drive_frame(input int nb, input bit with_last, input bit gaps);
        for (int b = 0; b < nb; b++) begin
            int t;
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            bus.in_valid = 1'b1;
            bus.in_data  = pw[b];
            bus.in_last  = with_last && (b == nb-1);
            t = 0;
            @(negedge clk);
            while (!bus.in_ready && t < 200) begin @(negedge clk); t++; end
            if (!bus.in_ready) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: bin %0d, got in_ready=%0b, required 1 within 200 cycles", b, bus.in_ready);
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 3000) begin @(negedge clk); t++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats outstanding, required 0", sb.size());
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        load_rom_mel();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 7;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", bus.in_ready); end
        if (bus.rom_addr !== '0) begin errors++; $display("FAIL rst_rom_addr: got %0h, required 0", bus.rom_addr); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); end
        if (bus.out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %0h, required 0", bus.out_data); end
        if (bus.out_idx !== '0) begin errors++; $display("FAIL rst_out_idx: got %0d, required 0", bus.out_idx); end
        if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b, required 0", bus.out_last); end
        if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b, required 0", bus.frame_err); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b, required 1", bus.in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string name, input int nb, input bit with_last, input bit gaps, input int exp_err);
        int e0, l0;
        e0 = err_pulses;
        l0 = lasts_seen;
        model_frame(nb);
        push_exp(N_FILT);
        drive_frame(nb, with_last, gaps);
        wait_drain();
        checks += 2;
        if (err_pulses - e0 != exp_err) begin
            errors++;
            $display("FAIL %s frame_err: got %0d pulses, required %0d", name, err_pulses - e0, exp_err);
        end
        if (lasts_seen - l0 != 1) begin
            errors++;
            $display("FAIL %s out_last: got %0d, required 1", name, lasts_seen - l0);
        end
    endtask

    task automatic test_single_filter();
        load_rom_single();
        for (int b = 0; b < N_BINS; b++) pw[b] = 1;
        run_frame("single_filter", N_BINS, 1'b1, 1'b0, 0);
    endtask

    task automatic test_full_mel();
        load_rom_mel();
        for (int b = 0; b < N_BINS; b++) pw[b] = 1000;
        run_frame("full_mel", N_BINS, 1'b1, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        load_rom_mel();
        rdy_rand = 1'b1;
        for (int b = 0; b < N_BINS; b++) pw[b] = $urandom();
        run_frame("backpressure_gaps", N_BINS, 1'b1, 1'b1, 0);
        for (int b = 0; b < N_BINS; b++) pw[b] = $urandom();
        run_frame("backpressure_dense", N_BINS, 1'b1, 1'b0, 0);
        rdy_rand = 1'b0;
    endtask

    task automatic test_frame_err();
        load_rom_mel();
        for (int b = 0; b < N_BINS; b++) pw[b] = $urandom_range(1, 100000);
        run_frame("early_last", 101, 1'b1, 1'b0, 1);
        run_frame("missing_last", N_BINS, 1'b0, 1'b0, 1);
        run_frame("after_err", N_BINS, 1'b1, 1'b0, 0);
    endtask

    task automatic test_max_power();
        load_rom_single();
        for (int b = 0; b < N_BINS; b++) pw[b] = '1;
        run_frame("max_power", N_BINS, 1'b1, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        int f50, n_early;
        load_rom_mel();
        for (int b = 0; b < N_BINS; b++) pw[b] = $urandom();
        // filters completed before the abort are emitted normally
        model_frame(51);
        f50 = int'(rom[N_BINS + 50]);
        n_early = (f50 >= 1) ? f50 - 1 : 0;
        push_exp(n_early);
        drive_frame(51, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 6;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b, required 0", bus.out_valid); end
        if (bus.out_data !== '0) begin errors++; $display("FAIL mid_rst_out_data: got %0h, required 0", bus.out_data); end
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready: got %b, required 0", bus.in_ready); end
        if (bus.rom_addr !== '0) begin errors++; $display("FAIL mid_rst_rom_addr: got %0h, required 0", bus.rom_addr); end
        if (bus.out_idx !== '0) begin errors++; $display("FAIL mid_rst_out_idx: got %0d, required 0", bus.out_idx); end
        if (sb.size() != 0) begin errors++; $display("FAIL mid_rst_pending: got %0d beats outstanding, required 0", sb.size()); end
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        run_frame("after_mid_reset", N_BINS, 1'b1, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_single_filter();
        test_full_mel();
        test_back_to_back();
        test_frame_err();
        test_max_power();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
